// File: rtl/tree_ensemble_pkg.sv
// Shared types, node-word layout and width helpers for the tree ensemble evaluator.
package tree_ensemble_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WALK = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Ceiling log2, never below 1 so every derived vector has at least one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int feat_w(input int n_feat);
    return clog2_min1(n_feat);
  endfunction

  function automatic int child_w(input int nodes_per_tree);
    return clog2_min1(nodes_per_tree);
  endfunction

  function automatic int addr_w(input int n_trees, input int nodes_per_tree);
    return clog2_min1(n_trees * nodes_per_tree);
  endfunction

  function automatic int node_w(input int n_feat, input int nodes_per_tree);
    return 2 + feat_w(n_feat) + 2 * child_w(nodes_per_tree);
  endfunction

  function automatic int vote_w(input int n_trees);
    return clog2_min1(n_trees + 1);
  endfunction

  function automatic int tree_w(input int n_trees);
    return clog2_min1(n_trees);
  endfunction

  function automatic int depth_w(input int max_depth);
    return clog2_min1(max_depth + 1);
  endfunction

  // Node word is {leaf, value, feat, hi_child, lo_child}, MSB first.
  function automatic int lo_lsb();
    return 0;
  endfunction

  function automatic int hi_lsb(input int cw);
    return cw;
  endfunction

  function automatic int feat_lsb(input int cw);
    return 2 * cw;
  endfunction

  function automatic int value_bit(input int fw, input int cw);
    return 2 * cw + fw;
  endfunction

  function automatic int leaf_bit(input int fw, input int cw);
    return 2 * cw + fw + 1;
  endfunction

endpackage

// File: rtl/tree_ensemble_eval_tree_node_step.sv
// Combinational decode of one node word: leaf flag, leaf value and the child to follow.
module tree_node_step
  import tree_ensemble_pkg::*;
#(
  parameter int N_FEAT         = 51,
  parameter int NODES_PER_TREE = 32
) (
  input  logic [node_w(N_FEAT, NODES_PER_TREE)-1:0] node_i,
  input  logic [N_FEAT-1:0]                         feat_i,
  output logic [child_w(NODES_PER_TREE)-1:0]        next_o,
  output logic                                      leaf_o,
  output logic                                      value_o
);

  localparam int FEAT_W  = feat_w(N_FEAT);
  localparam int CHILD_W = child_w(NODES_PER_TREE);
  localparam int FEXT_W  = 1 << FEAT_W;

  logic [FEAT_W-1:0] feat_idx;
  logic [FEXT_W-1:0] feat_ext;

  // Zero-padding to the full index range makes any feat >= N_FEAT read as 0.
  assign feat_ext = FEXT_W'(feat_i);
  assign feat_idx = node_i[feat_lsb(CHILD_W) +: FEAT_W];
  assign leaf_o   = node_i[leaf_bit(FEAT_W, CHILD_W)];
  assign value_o  = node_i[value_bit(FEAT_W, CHILD_W)];
  assign next_o   = feat_ext[feat_idx] ? node_i[hi_lsb(CHILD_W) +: CHILD_W]
                                       : node_i[lo_lsb() +: CHILD_W];

endmodule

// File: rtl/tree_ensemble_eval.sv
// Walks every tree of a binary decision-tree ensemble, one node per cycle, and reports the majority vote.
module tree_ensemble_eval
  import tree_ensemble_pkg::*;
#(
  parameter int N_FEAT         = 51,
  parameter int N_TREES        = 4,
  parameter int NODES_PER_TREE = 32,
  parameter int MAX_DEPTH      = 8
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [N_FEAT-1:0]                           in_feat,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic                                        out_class,
  output logic [vote_w(N_TREES)-1:0]                  out_votes,
  output logic                                        out_err,
  input  logic                                        cfg_we,
  input  logic [addr_w(N_TREES, NODES_PER_TREE)-1:0]  cfg_addr,
  input  logic [node_w(N_FEAT, NODES_PER_TREE)-1:0]   cfg_data,
  output logic                                        cfg_ready
);

  localparam int CHILD_W = child_w(NODES_PER_TREE);
  localparam int ADDR_W  = addr_w(N_TREES, NODES_PER_TREE);
  localparam int NODE_W  = node_w(N_FEAT, NODES_PER_TREE);
  localparam int VOTE_W  = vote_w(N_TREES);
  localparam int TREE_W  = tree_w(N_TREES);
  localparam int DEPTH_W = depth_w(MAX_DEPTH);
  localparam int TOTAL   = N_TREES * NODES_PER_TREE;
  localparam logic [ADDR_W:0]   TOTAL_A    = (ADDR_W + 1)'(TOTAL);
  localparam logic [NODE_W-1:0] RESET_WORD = NODE_W'(1) << leaf_bit(feat_w(N_FEAT), CHILD_W);

  function automatic logic majority(input logic [VOTE_W-1:0] v);
    logic [VOTE_W:0] dbl;
    dbl = {v, 1'b0};
    return dbl > (VOTE_W + 1)'(N_TREES);
  endfunction

  state_e              state_q, state_d;
  logic [N_FEAT-1:0]   feat_q, feat_d;
  logic [TREE_W-1:0]   tree_q, tree_d;
  logic [CHILD_W-1:0]  node_q, node_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic [VOTE_W-1:0]   votes_q, votes_d;
  logic                err_q, err_d;
  logic                oclass_q, oclass_d;
  logic [VOTE_W-1:0]   ovotes_q, ovotes_d;
  logic                oerr_q, oerr_d;
  logic [NODE_W-1:0]   table_q [TOTAL];

  logic [ADDR_W-1:0]   rd_addr;
  logic [CHILD_W-1:0]  step_next;
  logic                step_leaf, step_value;
  logic                resolved, addr_ok, tbl_we;

  // Node slots per tree is a power of two, so the flat address is just {tree, node}.
  assign rd_addr = ADDR_W'({tree_q, node_q});
  assign addr_ok = ({1'b0, cfg_addr} < TOTAL_A);
  assign tbl_we  = cfg_we & cfg_ready & addr_ok;

  tree_node_step #(
    .N_FEAT         (N_FEAT),
    .NODES_PER_TREE (NODES_PER_TREE)
  ) u_step (
    .node_i  (table_q[rd_addr]),
    .feat_i  (feat_q),
    .next_o  (step_next),
    .leaf_o  (step_leaf),
    .value_o (step_value)
  );

  always_comb begin
    state_d   = state_q;
    feat_d    = feat_q;
    tree_d    = tree_q;
    node_d    = node_q;
    depth_d   = depth_q;
    votes_d   = votes_q;
    err_d     = err_q;
    oclass_d  = oclass_q;
    ovotes_d  = ovotes_q;
    oerr_d    = oerr_q;
    in_ready  = 1'b0;
    cfg_ready = 1'b0;
    out_valid = 1'b0;
    resolved  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready  = 1'b1;
        cfg_ready = ~in_valid;
        if (in_valid) begin
          state_d = S_WALK;
          feat_d  = in_feat;
          tree_d  = '0;
          node_d  = '0;
          depth_d = '0;
          votes_d = '0;
          err_d   = 1'b0;
        end
      end
      S_WALK: begin
        if (step_leaf) begin
          votes_d  = votes_q + VOTE_W'(step_value);
          resolved = 1'b1;
        end else if (depth_q == DEPTH_W'(MAX_DEPTH - 1)) begin
          // This visit is the last one allowed: the tree times out and votes 0.
          err_d    = 1'b1;
          resolved = 1'b1;
        end else begin
          node_d  = step_next;
          depth_d = depth_q + 1'b1;
        end
        if (resolved) begin
          node_d  = '0;
          depth_d = '0;
          if (tree_q == TREE_W'(N_TREES - 1)) begin
            state_d  = S_DONE;
            oclass_d = majority(votes_d);
            ovotes_d = votes_d;
            oerr_d   = err_d;
          end else begin
            tree_d = tree_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      oclass_q <= 1'b0;
      ovotes_q <= '0;
      oerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      oclass_q <= oclass_d;
      ovotes_q <= ovotes_d;
      oerr_q   <= oerr_d;
    end
  end

  always_ff @(posedge clk) begin
    feat_q  <= feat_d;
    tree_q  <= tree_d;
    node_q  <= node_d;
    depth_q <= depth_d;
    votes_q <= votes_d;
    err_q   <= err_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TOTAL; i++) table_q[i] <= RESET_WORD;
    end else if (tbl_we) begin
      table_q[cfg_addr] <= cfg_data;
    end
  end

  assign out_class = oclass_q;
  assign out_votes = ovotes_q;
  assign out_err   = oerr_q;

endmodule
